// File: rtl/vfu_wb_arbiter.sv
// VRF bank write-back arbiter: round-robin between ALU and MFPU results,
// one-entry output register towards the bank write port.
module vfu_wb_arbiter #(
    parameter  int unsigned NrVInsn    = 8,
    parameter  int unsigned VAddrWidth = 10,
    parameter  int unsigned DataWidth  = 64,
    localparam int unsigned StrbWidth  = DataWidth / 8,
    localparam int unsigned IdWidth    = (NrVInsn > 1) ? $clog2(NrVInsn) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  alu_result_req_i,
    input  logic [IdWidth-1:0]    alu_result_id_i,
    input  logic [VAddrWidth-1:0] alu_result_addr_i,
    input  logic [DataWidth-1:0]  alu_result_wdata_i,
    input  logic [StrbWidth-1:0]  alu_result_be_i,
    output logic                  alu_result_gnt_o,
    input  logic                  mfpu_result_req_i,
    input  logic [IdWidth-1:0]    mfpu_result_id_i,
    input  logic [VAddrWidth-1:0] mfpu_result_addr_i,
    input  logic [DataWidth-1:0]  mfpu_result_wdata_i,
    input  logic [StrbWidth-1:0]  mfpu_result_be_i,
    output logic                  mfpu_result_gnt_o,
    output logic                  wr_valid_o,
    output logic [IdWidth-1:0]    wr_id_o,
    output logic [VAddrWidth-1:0] wr_addr_o,
    output logic [DataWidth-1:0]  wr_data_o,
    output logic [StrbWidth-1:0]  wr_be_o,
    input  logic                  wr_ready_i,
    output logic [NrVInsn-1:0]    wb_pending_o
);

    logic                  stage_valid;
    logic [IdWidth-1:0]    stage_id;
    logic [VAddrWidth-1:0] stage_addr;
    logic [DataWidth-1:0]  stage_data;
    logic [StrbWidth-1:0]  stage_be;
    logic                  rr_q;
    logic                  can_accept;

    // Grant: stage must be free or draining; rr_q only breaks ties.
    always_comb begin
        can_accept        = 1'b0;
        alu_result_gnt_o  = 1'b0;
        mfpu_result_gnt_o = 1'b0;
        can_accept        = !rst_i && (!stage_valid || wr_ready_i);
        if (can_accept) begin
            alu_result_gnt_o  = alu_result_req_i &&
                                (!mfpu_result_req_i || !rr_q);
            mfpu_result_gnt_o = mfpu_result_req_i &&
                                (!alu_result_req_i || rr_q);
        end
    end

    // Round-robin pointer moves to the loser of each grant.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_q <= 1'b0;
        end else if (alu_result_gnt_o) begin
            rr_q <= 1'b1;
        end else if (mfpu_result_gnt_o) begin
            rr_q <= 1'b0;
        end
    end

    // Output stage: load on grant, clear on retire, otherwise hold.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stage_valid <= 1'b0;
            stage_id    <= '0;
            stage_addr  <= '0;
            stage_data  <= '0;
            stage_be    <= '0;
        end else if (alu_result_gnt_o) begin
            stage_valid <= 1'b1;
            stage_id    <= alu_result_id_i;
            stage_addr  <= alu_result_addr_i;
            stage_data  <= alu_result_wdata_i;
            stage_be    <= alu_result_be_i;
        end else if (mfpu_result_gnt_o) begin
            stage_valid <= 1'b1;
            stage_id    <= mfpu_result_id_i;
            stage_addr  <= mfpu_result_addr_i;
            stage_data  <= mfpu_result_wdata_i;
            stage_be    <= mfpu_result_be_i;
        end else if (wr_ready_i) begin
            stage_valid <= 1'b0;
        end
    end

    // Valid is masked during reset so an in-flight write is never delivered.
    always_comb begin
        wr_valid_o   = stage_valid && !rst_i;
        wr_id_o      = stage_id;
        wr_addr_o    = stage_addr;
        wr_data_o    = stage_data;
        wr_be_o      = stage_be;
        wb_pending_o = wr_valid_o ? (NrVInsn'(1) << stage_id) : '0;
    end

endmodule
